// File: rtl/delta3_sequencer.sv
// Sequencer for the output-layer delta pass: reads a3/t per neuron, latches delta/cost, writes delta.
// Optional cost accumulation is built only when DELTA3_COST_ACCUM_EN is defined.
module delta3_sequencer #(
    parameter int DWIDTH     = 16,
    parameter int AWIDTH     = 10,
    parameter int NOUT       = 16,
    parameter int DELTA_BASE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [AWIDTH-1:0]        rd_addr,
    output logic                     en_delta3,
    output logic                     en_cost,
    input  logic signed [DWIDTH-1:0] delta3,
    input  logic signed [DWIDTH-1:0] cost,
    output logic                     wr_en,
    output logic [AWIDTH-1:0]        wr_addr,
    output logic signed [DWIDTH-1:0] wr_data,
    output logic signed [DWIDTH-1:0] cost_sum
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] LATCH = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [AWIDTH-1:0] LAST_IDX  = AWIDTH'(NOUT - 1);
    localparam logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(DELTA_BASE);

    logic [2:0]        state_q, state_d;
    logic [AWIDTH-1:0] index_q, index_d;
    logic              accept;

    assign accept = (state_q == IDLE) && start && !abort;

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = READ;
                    index_d = '0;
                end
            end
            READ:  state_d = WAIT;
            WAIT:  state_d = LATCH;
            LATCH: state_d = WRITE;
            WRITE: begin
                if (index_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    state_d = READ;
                    index_d = index_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort outranks every transition; the index is left as-is and re-cleared on the next start.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign rd_en     = (state_q == READ);
    assign en_delta3 = (state_q == LATCH);
    assign wr_en     = (state_q == WRITE);
    assign rd_addr   = index_q;
    assign wr_addr   = BASE_ADDR + index_q;
    assign wr_data   = delta3;

`ifdef DELTA3_COST_ACCUM_EN
    logic signed [DWIDTH-1:0] cost_sum_q, cost_sum_d;
    logic        [DWIDTH:0]   sum_wide;

    always_comb begin
        cost_sum_d = cost_sum_q;
        sum_wide   = {cost_sum_q[DWIDTH-1], cost_sum_q} + {cost[DWIDTH-1], cost};
        if (accept) begin
            cost_sum_d = '0;
        end else if ((state_q == WRITE) && !abort) begin
            // Disagreeing top two bits of the extended sum mean signed overflow: clamp instead of wrapping.
            if (sum_wide[DWIDTH] != sum_wide[DWIDTH-1]) begin
                cost_sum_d = sum_wide[DWIDTH] ? {1'b1, {(DWIDTH-1){1'b0}}}
                                              : {1'b0, {(DWIDTH-1){1'b1}}};
            end else begin
                cost_sum_d = sum_wide[DWIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cost_sum_q <= '0;
        end else begin
            cost_sum_q <= cost_sum_d;
        end
    end

    assign en_cost  = (state_q == LATCH);
    assign cost_sum = cost_sum_q;
`else
    logic unused_cost;

    assign unused_cost = ^cost;
    assign en_cost     = 1'b0;
    assign cost_sum    = '0;
`endif

endmodule

// File: tb/tb_delta3_sequencer.sv
// Self-checking bench for delta3_sequencer: a cycle-count model of the pass plus directed literal checks.
// Expected cost behaviour follows DELTA3_COST_ACCUM_EN, matching the build of the design.
module tb_delta3_sequencer;

    localparam int NOUT = 4;

`ifdef DELTA3_COST_ACCUM_EN
    localparam bit COST_EN = 1'b1;
`else
    localparam bit COST_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;

    logic               busy, done, rd_en, en_delta3, en_cost, wr_en;
    logic [9:0]         rd_addr, wr_addr;
    logic signed [15:0] wr_data, cost_sum;

    logic               w_busy, w_done, w_rd_en, w_en_delta3, w_en_cost, w_wr_en;
    logic [3:0]         w_rd_addr, w_wr_addr;
    logic signed [15:0] w_wr_data, w_cost_sum;

    logic signed [15:0] dp_delta = '0;
    logic signed [15:0] dp_cost  = '0;
    logic [1:0]         addr_lat = '0;
    logic signed [15:0] delta_arr [NOUT];
    logic signed [15:0] cost_arr  [NOUT];

    int   n_vec  = 0;
    int   n_fail = 0;
    logic check_en = 1'b0;

    logic m_busy = 1'b0;
    int   m_t    = 0;
    int   m_sum  = 0;

    delta3_sequencer #(.DWIDTH(16), .AWIDTH(10), .NOUT(NOUT), .DELTA_BASE(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .en_delta3(en_delta3), .en_cost(en_cost), .delta3(dp_delta), .cost(dp_cost),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cost_sum(cost_sum)
    );

    // Second copy with a base near the top of a 4-bit address space, so the write address must wrap.
    delta3_sequencer #(.DWIDTH(16), .AWIDTH(4), .NOUT(NOUT), .DELTA_BASE(14)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(w_busy), .done(w_done), .rd_en(w_rd_en), .rd_addr(w_rd_addr),
        .en_delta3(w_en_delta3), .en_cost(w_en_cost), .delta3(dp_delta), .cost(dp_cost),
        .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data), .cost_sum(w_cost_sum)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: one-cycle memory read, then delta/cost registers loaded on the latch strobe.
    always @(posedge clk) begin
        if (rd_en) addr_lat <= rd_addr[1:0];
        if (en_delta3) begin
            dp_delta <= delta_arr[addr_lat];
            dp_cost  <= cost_arr[addr_lat];
        end
    end

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: m_t counts cycles since the accepted start (READ of neuron 0 is 1, done is 4*NOUT+1).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_t    = 0;
            m_sum  = 0;
        end else if (!m_busy) begin
            if (start && !abort) begin
                m_busy = 1'b1;
                m_t    = 1;
                m_sum  = 0;
            end
        end else if (abort) begin
            m_busy = 1'b0;
        end else begin
            if ((m_t <= 4 * NOUT) && (m_t % 4 == 0))
                m_sum = sat16(m_sum + int'(cost_arr[m_t / 4 - 1]));
            if (m_t == 4 * NOUT + 1) m_busy = 1'b0;
            else m_t = m_t + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a);
        start = s;
        abort = a;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic e_rd, e_lat, e_wr, e_done;
        int   n;
        logic [15:0] e_sum;
        if (check_en) begin
            e_rd = 1'b0; e_lat = 1'b0; e_wr = 1'b0; e_done = 1'b0; n = 0;
            if (m_busy) begin
                if (m_t <= 4 * NOUT) begin
                    n     = (m_t - 1) / 4;
                    e_rd  = ((m_t - 1) % 4 == 0);
                    e_lat = ((m_t - 1) % 4 == 2);
                    e_wr  = ((m_t - 1) % 4 == 3);
                end else begin
                    e_done = 1'b1;
                end
            end
            e_sum = COST_EN ? 16'(m_sum) : 16'h0000;
            checkOutput("busy", busy, m_busy);
            checkOutput("done", done, e_done);
            checkOutput("rd_en", rd_en, e_rd);
            checkOutput("en_delta3", en_delta3, e_lat);
            checkOutput("en_cost", en_cost, e_lat & COST_EN);
            checkOutput("wr_en", wr_en, e_wr);
            checkOutput("cost_sum", 32'(unsigned'(cost_sum)), 32'(e_sum));
            checkOutput("w_busy", w_busy, m_busy);
            checkOutput("w_done", w_done, e_done);
            checkOutput("w_wr_en", w_wr_en, e_wr);
            checkOutput("w_cost_sum", 32'(unsigned'(w_cost_sum)), 32'(e_sum));
            if (e_rd) begin
                checkOutput("rd_addr", rd_addr, 32'(n));
                checkOutput("w_rd_addr", w_rd_addr, 32'(n));
            end
            if (e_wr) begin
                checkOutput("wr_addr", wr_addr, 32'(16 + n));
                checkOutput("w_wr_addr", w_wr_addr, 32'((14 + n) % 16));
                checkOutput("wr_data", 32'(unsigned'(wr_data)), 32'(unsigned'(delta_arr[n])));
                checkOutput("w_wr_data", 32'(unsigned'(w_wr_data)), 32'(unsigned'(delta_arr[n])));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int wr_cyc [$];
        int wr_adr [$];
        int wr_dat [$];

        for (int i = 0; i < NOUT; i++) begin
            delta_arr[i] = 16'(i);
            cost_arr[i]  = 16'h0100;
        end
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_rd_en", rd_en, 0);
        checkOutput("reset_wr_en", wr_en, 0);
        checkOutput("reset_cost_sum", 32'(unsigned'(cost_sum)), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        check_en = 1'b1;
        repeat (2) applyStimulus(1'b0, 1'b0);

        // Index-valued deltas, 0x0100 costs: writes on cycles 4,8,12,16 and done on 17.
        applyStimulus(1'b1, 1'b0);
        for (int c = 1; c <= 17; c++) begin
            if (wr_en) begin
                wr_cyc.push_back(c);
                wr_adr.push_back(int'(wr_addr));
                wr_dat.push_back(int'(wr_data));
            end
            if (c == 17) checkOutput("done_at_17", done, 1);
            else applyStimulus(1'b0, 1'b0);
        end
        checkOutput("write_count", wr_cyc.size(), 4);
        for (int k = 0; k < wr_cyc.size() && k < 4; k++) begin
            checkOutput("write_cycle", wr_cyc[k], 4 * (k + 1));
            checkOutput("write_addr", wr_adr[k], 16 + k);
            checkOutput("write_data", wr_dat[k], k);
        end
        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("sum_0400_held", 32'(unsigned'(cost_sum)), COST_EN ? 32'h0400 : 32'h0);

        // Large costs must clamp at the positive limit.
        for (int i = 0; i < NOUT; i++) cost_arr[i] = 16'h7000;
        applyStimulus(1'b1, 1'b0);
        repeat (19) applyStimulus(1'b0, 1'b0);
        checkOutput("sum_saturated", 32'(unsigned'(cost_sum)), COST_EN ? 32'h7FFF : 32'h0);

        // Abort while waiting on neuron 2's read: back to idle, partial sum of two neurons kept.
        for (int i = 0; i < NOUT; i++) cost_arr[i] = 16'h0100;
        applyStimulus(1'b1, 1'b0);
        repeat (9) applyStimulus(1'b0, 1'b0);
        checkOutput("abort_in_wait_busy", busy, 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("abort_idle", busy, 0);
        repeat (8) applyStimulus(1'b0, 1'b0);
        checkOutput("abort_partial_sum", 32'(unsigned'(cost_sum)), COST_EN ? 32'h0200 : 32'h0);

        applyStimulus(1'b1, 1'b1);
        checkOutput("abort_beats_start", busy, 0);

        // Start repeated while busy is ignored; reset lands in the middle of neuron 2's write.
        applyStimulus(1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        repeat (7) applyStimulus(1'b0, 1'b0);
        checkOutput("pre_reset_wr_en", wr_en, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_wr_en", wr_en, 0);
        checkOutput("async_busy", busy, 0);
        checkOutput("async_done", done, 0);
        checkOutput("async_cost_sum", 32'(unsigned'(cost_sum)), 0);
        checkOutput("async_w_wr_en", w_wr_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) applyStimulus(1'b0, 1'b0);
        checkOutput("post_reset_idle", busy, 0);

        // Random traffic; new per-neuron data only while the model is idle.
        for (int c = 0; c < 600; c++) begin
            if (!m_busy && ($urandom_range(0, 1) == 1)) begin
                for (int i = 0; i < NOUT; i++) begin
                    delta_arr[i] = 16'($urandom);
                    cost_arr[i]  = 16'($urandom);
                end
            end
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
        end
        repeat (20) applyStimulus(1'b0, 1'b0);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/delta3_sequencer.md
DELTA3_SEQUENCER -- requirements
Module: delta3_sequencer

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, data width of the a3/t/delta/cost words.
REQ-002 SHALL have parameter AWIDTH, default 10, memory address width.
REQ-003 SHALL have parameter NOUT, default 16, number of output neurons to process, range 1..2^AWIDTH.
REQ-004 SHALL have parameter DELTA_BASE, default 0, base write address in the delta memory.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: level-sampled request to begin one delta-3 pass.
REQ-008 SHALL have port abort, input, 1 bit: synchronous cancel of a running pass.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a complete pass.
REQ-011 SHALL have port rd_en, output, 1 bit: read strobe to the shared a3/t memories.
REQ-012 SHALL have port rd_addr, output, AWIDTH bits: neuron index for the a3 and t reads.
REQ-013 SHALL have port en_delta3, output, 1 bit: capture enable for the datapath delta register.
REQ-014 SHALL have port en_cost, output, 1 bit: capture enable for the datapath cost register.
REQ-015 SHALL have port delta3, input, DWIDTH bits, signed: registered delta from the datapath.
REQ-016 SHALL have port cost, input, DWIDTH bits, signed: registered squared error from the datapath.
REQ-017 SHALL have port wr_en, output, 1 bit: write strobe to the delta memory.
REQ-018 SHALL have port wr_addr, output, AWIDTH bits: DELTA_BASE + neuron index.
REQ-019 SHALL have port wr_data, output, DWIDTH bits, signed: equal to delta3 while wr_en is high.
REQ-020 SHALL have port cost_sum, output, DWIDTH bits, signed: accumulated cost of the current/last pass.

Function
REQ-021 SHALL implement states IDLE, READ, WAIT, LATCH, WRITE, DONE.
REQ-022 IDLE with start=1 SHALL clear the index and cost_sum, then go to READ; start is ignored while busy=1.
REQ-023 READ SHALL drive rd_en=1 and rd_addr=index for exactly one cycle, then go to WAIT (1-cycle memory read latency).
REQ-024 WAIT SHALL hold all strobes low, then go to LATCH.
REQ-025 LATCH SHALL drive en_delta3=1 and en_cost=1 for exactly one cycle, then go to WRITE.
REQ-026 WRITE SHALL drive wr_en=1, wr_addr=DELTA_BASE+index, and wr_data=delta3, and SHALL add cost into cost_sum.
REQ-027 After WRITE, the block SHALL go to READ with index+1 if index<NOUT-1, otherwise to DONE.
REQ-028 DONE SHALL assert done=1 for one cycle, then go to IDLE; cost_sum SHALL hold until the next accepted start.
REQ-029 Latency: with start sampled at edge 0, done SHALL be high in cycle 4*NOUT+1; each neuron takes exactly 4 cycles.
REQ-030 cost_sum addition SHALL saturate to the signed DWIDTH range (max 0x7FFF, min 0x8000 at 16 bits), never wrap.
REQ-031 wr_addr SHALL wrap modulo 2^AWIDTH if DELTA_BASE+index overflows.
REQ-032 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done pulse and no further strobes; cost_sum SHALL hold its partial value.
REQ-033 abort and start together in IDLE: abort SHALL win and the block SHALL stay in IDLE.
REQ-034 At most one of rd_en, en_delta3, or wr_en SHALL be high in any cycle.

Reset
REQ-035 rst_n=0 SHALL immediately force state IDLE, index 0, cost_sum 0, and all strobes, done, and busy to 0, regardless of clk.
REQ-036 Reset mid-pass SHALL discard the pass; after release the block SHALL wait for a new start.

Configuration
REQ-037 With macro DELTA3_COST_ACCUM_EN defined, en_cost and cost_sum SHALL behave as in REQ-025, REQ-026 and REQ-030.
REQ-038 Without DELTA3_COST_ACCUM_EN, en_cost SHALL be constant 0, cost_sum SHALL be constant 0, and the cost input SHALL be ignored; all sequencing and timing SHALL be unchanged.

Verification
REQ-039 Run NOUT=4, DELTA_BASE=0x10, with the delta3 model returning the index; pulse start -> wr_en at cycles 4, 8, 12, 16 to addresses 0x10..0x13 with data 0..3, and done high at cycle 17.
REQ-040 Feed cost=0x0100 per neuron with NOUT=4 and DELTA3_COST_ACCUM_EN defined -> cost_sum=0x0400 after done, held through IDLE.
REQ-041 Feed cost=0x7000 per neuron with NOUT=4 -> cost_sum saturates at 0x7FFF with no wrap.
REQ-042 Assert abort in the WAIT state of neuron 2 -> IDLE on the next edge, no wr_en for neuron 2, no done, busy=0.
REQ-043 Pulse start while busy, and assert rst_n=0 mid-WRITE -> the second start is ignored; the reset clears all outputs asynchronously with no done.
REQ-044 Build without DELTA3_COST_ACCUM_EN -> en_cost and cost_sum stay 0, and the REQ-039 timing is unchanged.
